// File: rtl/prog_clock_divider_pkg.sv
// ---------------------------------------------------------------------------
// prog_clock_divider_pkg
//
// Shared definitions for the programmable clock divider:
//   - MIN_DIV      : smallest legal half-period; a requested divisor of 0 is
//                    promoted to this value.
//   - ch_width()   : width of the channel-select field for a given channel
//                    count (never narrower than one bit).
//   - ch_mode_e    : per-cycle operating mode of a divider channel.
// ---------------------------------------------------------------------------
package prog_clock_divider_pkg;

    localparam int MIN_DIV = 1;

    // A single-channel divider still needs a one-bit select port so that the
    // interface shape does not change with N_CH.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // SYNC wins over everything, RUN is an enabled channel, IDLE a disabled
    // one. The mode is decoded once per cycle and drives the next-state logic.
    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_SYNC = 2'd2
    } ch_mode_e;

endpackage

// File: rtl/divider_channel.sv
// ---------------------------------------------------------------------------
// divider_channel
//
// One independent divider channel. Produces a 50% duty square wave whose
// half-period is div_q clock cycles, plus a one-cycle tick at every toggle.
// Divisor updates written while the channel runs are held as "pending" and
// only applied at a terminal count, so a half-period is never truncated.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   en       in   count enable
//   sync     in   force phase alignment (clear count and output)
//   wr       in   accepted divisor write aimed at this channel
//   wr_div   in   divisor to write (already promoted from 0 to 1)
//   ready    out  channel can accept a write (no update pending)
//   clk_div  out  divided square wave
//   tick     out  one-cycle pulse coincident with each clk_div toggle
// ---------------------------------------------------------------------------
module divider_channel
    import prog_clock_divider_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
    output logic             ready,
    output logic             clk_div,
    output logic             tick
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(MIN_DIV);

    logic [WIDTH-1:0] count_q,   count_nxt;
    logic [WIDTH-1:0] div_q,     div_nxt;
    logic [WIDTH-1:0] pend_q,    pend_nxt;
    logic             pending_q, pending_nxt;
    logic             clk_q,     clk_nxt;
    logic             tick_q,    tick_nxt;

    ch_mode_e mode;
    logic     terminal;

    // Sync overrides the enable; otherwise the enable picks run versus idle.
    always_comb begin
        mode = MODE_IDLE;
        if (sync) begin
            mode = MODE_SYNC;
        end else if (en) begin
            mode = MODE_RUN;
        end
    end

    // The count never exceeds div_q-1 because every divisor change also
    // clears the count; using >= keeps the compare from ever wrapping past
    // the terminal value even if that invariant were somehow broken.
    assign terminal = (count_q >= (div_q - ONE));

    // Next-state logic. All registers hold by default and tick is a pulse,
    // so it defaults low. A write can only arrive when nothing is pending
    // (ready gates it), so the write and pending paths never collide.
    always_comb begin
        count_nxt   = count_q;
        div_nxt     = div_q;
        pend_nxt    = pend_q;
        pending_nxt = pending_q;
        clk_nxt     = clk_q;
        tick_nxt    = 1'b0;

        unique case (mode)
            MODE_SYNC: begin
                // Phase-align: restart every channel from a low output. A write
                // in the same cycle lands directly; otherwise a queued update
                // is flushed into the divisor here.
                count_nxt = '0;
                clk_nxt   = 1'b0;
                if (wr) begin
                    div_nxt     = wr_div;
                    pending_nxt = 1'b0;
                end else if (pending_q) begin
                    div_nxt     = pend_q;
                    pending_nxt = 1'b0;
                end
            end

            MODE_RUN: begin
                if (terminal) begin
                    count_nxt = '0;
                    clk_nxt   = ~clk_q;
                    tick_nxt  = 1'b1;
                    if (pending_q) begin
                        div_nxt     = pend_q;
                        pending_nxt = 1'b0;
                    end
                end else begin
                    count_nxt = count_q + ONE;
                end
                // A write in a terminal cycle still waits for the following
                // terminal, since the current one already used the old divisor.
                if (wr) begin
                    pend_nxt    = wr_div;
                    pending_nxt = 1'b1;
                end
            end

            MODE_IDLE: begin
                // A stopped channel has no half-period to protect, so updates
                // go straight into the divisor and the count restarts.
                if (wr) begin
                    div_nxt   = wr_div;
                    count_nxt = '0;
                end else if (pending_q) begin
                    div_nxt     = pend_q;
                    pending_nxt = 1'b0;
                    count_nxt   = '0;
                end
            end

            default: begin
            end
        endcase
    end

    // Channel state registers; reset drops any queued divisor update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            div_q     <= RESET_DIV;
            pend_q    <= RESET_DIV;
            pending_q <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_nxt;
            div_q     <= div_nxt;
            pend_q    <= pend_nxt;
            pending_q <= pending_nxt;
            clk_q     <= clk_nxt;
            tick_q    <= tick_nxt;
        end
    end

    assign ready   = ~pending_q;
    assign clk_div = clk_q;
    assign tick    = tick_q;

endmodule

// File: rtl/prog_clock_divider.sv
// ---------------------------------------------------------------------------
// prog_clock_divider
//
// Bank of N_CH programmable clock dividers sharing one configuration port.
// The top level only decodes configuration writes and muxes the addressed
// channel's ready flag; all counting lives in divider_channel.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   per-channel count enable [N_CH]
//   sync       in   phase-align all channels
//   cfg_valid  in   divisor write request
//   cfg_ch     in   target channel of the write
//   cfg_div    in   new half-period in clk cycles (0 is treated as 1)
//   cfg_ready  out  write is accepted this cycle (combinational)
//   clk_div    out  divided square wave per channel [N_CH]
//   tick       out  one-cycle pulse per channel at each toggle [N_CH]
// ---------------------------------------------------------------------------
module prog_clock_divider
    import prog_clock_divider_pkg::*;
#(
    parameter int          N_CH        = 4,
    parameter int          WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           en,
    input  logic                      sync,
    input  logic                      cfg_valid,
    input  logic [ch_width(N_CH)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]          cfg_div,
    output logic                      cfg_ready,
    output logic [N_CH-1:0]           clk_div,
    output logic [N_CH-1:0]           tick
);

    logic [N_CH-1:0]  ch_ready;
    logic [N_CH-1:0]  ch_wr;
    logic [WIDTH-1:0] wr_div;
    logic             accept;

    // Ready mux: an address beyond the last channel matches nothing and so
    // reports ready, which lets such writes be accepted and silently dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(cfg_ch) == i) begin
                cfg_ready = ch_ready[i];
            end
        end
    end

    assign accept = cfg_valid & cfg_ready;

    // A zero half-period is meaningless, so it is promoted to the minimum.
    assign wr_div = (cfg_div == '0) ? WIDTH'(MIN_DIV) : cfg_div;

    // Write strobe decode: one-hot on the addressed channel, all-zero for
    // out-of-range addresses.
    always_comb begin
        ch_wr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(cfg_ch) == i) begin
                ch_wr[i] = accept;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        divider_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[g]),
            .sync    (sync),
            .wr      (ch_wr[g]),
            .wr_div  (wr_div),
            .ready   (ch_ready[g]),
            .clk_div (clk_div[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_prog_clock_divider
//
// Directed bench for prog_clock_divider with N_CH=2, WIDTH=8, DEFAULT_DIV=3.
// A table of per-cycle vectors covers start-up, enable freeze, deferred
// divisor updates, divisor 0, sync and write-during-sync; a hand-written
// sequence covers asynchronous reset with an update pending.
// Bit order of the two-bit vectors is {ch1, ch0}.
// ---------------------------------------------------------------------------
module tb_prog_clock_divider;

    typedef struct {
        logic [1:0] en;
        logic       sync;
        logic       cv;
        logic       cch;
        logic [7:0] cdiv;
        logic       exp_ready;
        logic [1:0] exp_clk;
        logic [1:0] exp_tick;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] en;
    logic       sync;
    logic       cfg_valid;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic [1:0] clk_div;
    logic [1:0] tick;

    int num_checks = 0;
    int num_fails  = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    prog_clock_divider #(
        .N_CH        (2),
        .WIDTH       (8),
        .DEFAULT_DIV (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_div   (clk_div),
        .tick      (tick)
    );

    function automatic vec_t mkVec(input logic [1:0] e, input logic s, input logic cv,
                                   input logic cch, input logic [7:0] cd, input logic rdy,
                                   input logic [1:0] ck, input logic [1:0] tk);
        vec_t v;
        v.en = e; v.sync = s; v.cv = cv; v.cch = cch; v.cdiv = cd;
        v.exp_ready = rdy; v.exp_clk = ck; v.exp_tick = tk;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        en        = v.en;
        sync      = v.sync;
        cfg_valid = v.cv;
        cfg_ch    = v.cch;
        cfg_div   = v.cdiv;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Fills the per-cycle table; each row is one clock edge.
    task automatic buildTable();
        // start-up: toggles at edges 3 and 6
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b00)); // 1
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b00)); // 2
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b11,2'b11)); // 3
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b11,2'b00)); // 4
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b11,2'b00)); // 5
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b11)); // 6
        // ch0 frozen for 4 cycles at count 1
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b00)); // 7
        vecs.push_back(mkVec(2'b10,0,0,0,8'd0, 1,2'b00,2'b00)); // 8
        vecs.push_back(mkVec(2'b10,0,0,0,8'd0, 1,2'b10,2'b10)); // 9
        vecs.push_back(mkVec(2'b10,0,0,0,8'd0, 1,2'b10,2'b00)); // 10
        vecs.push_back(mkVec(2'b10,0,0,0,8'd0, 1,2'b10,2'b00)); // 11
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b10)); // 12
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b01,2'b01)); // 13
        // deferred write ch0 div=5 at count 1; blocked second write of 7
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b01,2'b00)); // 14
        vecs.push_back(mkVec(2'b11,0,1,0,8'd5, 1,2'b11,2'b10)); // 15
        vecs.push_back(mkVec(2'b11,0,1,0,8'd7, 0,2'b10,2'b01)); // 16
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b10,2'b00)); // 17
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b10)); // 18
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b00)); // 19
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b00)); // 20
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b11,2'b11)); // 21
        // ch1 div=0 while disabled -> div 1
        vecs.push_back(mkVec(2'b01,0,1,1,8'd0, 1,2'b11,2'b00)); // 22
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b01,2'b10)); // 23
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b11,2'b10)); // 24
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b01,2'b10)); // 25
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b10,2'b11)); // 26
        // set ch0=3, ch1=4 while disabled, then sync
        vecs.push_back(mkVec(2'b00,0,1,0,8'd3, 1,2'b10,2'b00)); // 27
        vecs.push_back(mkVec(2'b00,0,1,1,8'd4, 1,2'b10,2'b00)); // 28
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b10,2'b00)); // 29
        vecs.push_back(mkVec(2'b11,1,0,0,8'd0, 1,2'b00,2'b00)); // 30
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b00)); // 31
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b00)); // 32
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b01,2'b01)); // 33
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b11,2'b10)); // 34
        // write ch0 div=2 together with sync
        vecs.push_back(mkVec(2'b11,1,1,0,8'd2, 1,2'b00,2'b00)); // 35
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b00)); // 36
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b01,2'b01)); // 37
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b01,2'b00)); // 38
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b10,2'b11)); // 39
        // pending on ch1, then disable applies it
        vecs.push_back(mkVec(2'b11,0,1,1,8'd2, 1,2'b10,2'b00)); // 40
        vecs.push_back(mkVec(2'b01,0,0,1,8'd0, 0,2'b11,2'b01)); // 41
        vecs.push_back(mkVec(2'b11,0,0,1,8'd0, 1,2'b11,2'b00)); // 42
        vecs.push_back(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b11)); // 43
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [1:0] exp_ck;
        logic [1:0] exp_tk;

        buildTable();
        applyStimulus(mkVec(2'b00,0,0,0,8'd0, 1,2'b00,2'b00));

        // reset state
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset.clk_div", 8'(clk_div), 8'h0);
        checkOutput("reset.tick", 8'(tick), 8'h0);
        checkOutput("reset.cfg_ready", 8'(cfg_ready), 8'h1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // table-driven vectors
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d.cfg_ready", i + 1), 8'(cfg_ready), 8'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            checkOutput($sformatf("row%0d.clk_div", i + 1), 8'(clk_div), 8'(vecs[i].exp_clk));
            checkOutput($sformatf("row%0d.tick", i + 1), 8'(tick), 8'(vecs[i].exp_tick));
        end

        // reset with an update pending on ch0 (both channels at div 2, count 0)
        applyStimulus(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b00));
        @(posedge clk);
        #1;
        checkOutput("rstseq.pre.clk_div", 8'(clk_div), 8'h0);
        applyStimulus(mkVec(2'b11,0,1,0,8'd6, 1,2'b00,2'b00));
        #1;
        checkOutput("rstseq.write.cfg_ready", 8'(cfg_ready), 8'h1);
        @(posedge clk);
        #1;
        applyStimulus(mkVec(2'b11,0,0,0,8'd0, 1,2'b00,2'b00));
        checkOutput("rstseq.term.clk_div", 8'(clk_div), 8'h3);
        checkOutput("rstseq.term.tick", 8'(tick), 8'h3);
        #1;
        checkOutput("rstseq.pending.cfg_ready", 8'(cfg_ready), 8'h0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstseq.async.clk_div", 8'(clk_div), 8'h0);
        checkOutput("rstseq.async.tick", 8'(tick), 8'h0);
        checkOutput("rstseq.async.cfg_ready", 8'(cfg_ready), 8'h1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            exp_ck = (k >= 3 && k <= 5) ? 2'b11 : 2'b00;
            exp_tk = (k == 3 || k == 6) ? 2'b11 : 2'b00;
            checkOutput($sformatf("rstseq.after%0d.clk_div", k), 8'(clk_div), 8'(exp_ck));
            checkOutput($sformatf("rstseq.after%0d.tick", k), 8'(tick), 8'(exp_tk));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
